// File: rtl/spi_slave_ctrl.sv
// SPI slave sequencer in the clk domain: shifts P_DATA_W-bit words MSB-first between
// pre-synchronized SCLK/CS_N strobes and a one-word tx holding buffer / rx valid pulse.
module spi_slave_ctrl #(
    parameter int P_DATA_W = 8,
    parameter bit P_CPOL   = 1'b0,
    parameter bit P_CPHA   = 1'b0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sclk_pe,
    input  logic                sclk_ne,
    input  logic                cs_n,
    input  logic                cs_n_ne,
    input  logic                cs_n_pe,
    input  logic                mosi,
    output logic                miso,
    output logic                miso_oe,
    input  logic [P_DATA_W-1:0] tx_data,
    input  logic                tx_valid,
    output logic                tx_ready,
    output logic [P_DATA_W-1:0] rx_data,
    output logic                rx_valid,
    output logic                tx_underrun,
    output logic                frame_err
);
    localparam int               CNT_W    = $clog2(P_DATA_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(P_DATA_W - 1);

    typedef enum logic {ST_IDLE, ST_XFER} state_t;

    state_t              state;
    logic [CNT_W-1:0]    bit_cnt;
    logic [P_DATA_W-2:0] rx_shift;
    logic [P_DATA_W-1:0] tx_shift;
    logic [P_DATA_W-1:0] tx_buf;
    logic [P_DATA_W-1:0] rx_next;
    logic [P_DATA_W-1:0] load_word;
    logic                load_pend;
    logic                sample_edge;
    logic                shift_edge;
    logic                in_xfer;
    logic                frame_end;
    logic                word_done;
    logic                do_load;
    logic                do_shift;
    logic                tx_write;

    assign sample_edge = (P_CPOL ^ P_CPHA) ? sclk_ne : sclk_pe;
    assign shift_edge  = (P_CPOL ^ P_CPHA) ? sclk_pe : sclk_ne;
    assign in_xfer     = (state == ST_XFER);
    // The cs_n level backs up the strobe so a missed cs_n_pe cannot leave a frame open.
    assign frame_end   = in_xfer && (cs_n_pe || cs_n);
    assign word_done   = in_xfer && sample_edge && (bit_cnt == LAST_BIT);
    assign rx_next     = {rx_shift, mosi};
    assign do_load     = (!in_xfer && cs_n_ne && !P_CPHA)
                       || (in_xfer && !frame_end && shift_edge && load_pend);
    assign do_shift    = in_xfer && !frame_end && shift_edge && !load_pend;
    assign load_word   = tx_ready ? '0 : tx_buf;
    assign tx_write    = tx_valid && tx_ready;
    assign miso        = tx_shift[P_DATA_W-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            bit_cnt     <= '0;
            rx_shift    <= '0;
            tx_shift    <= '0;
            tx_buf      <= '0;
            load_pend   <= 1'b0;
            miso_oe     <= 1'b0;
            tx_ready    <= 1'b1;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            tx_underrun <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            // NOTE: pulses default low each cycle; later assignments in this block override.
            rx_valid    <= 1'b0;
            tx_underrun <= 1'b0;
            frame_err   <= 1'b0;

            if (do_load) begin
                tx_shift    <= load_word;
                tx_underrun <= tx_ready;
            end else if (do_shift) begin
                tx_shift <= {tx_shift[P_DATA_W-2:0], 1'b0};
            end

            // A load sees the buffer as it was; a same-cycle write refills it afterwards.
            if (tx_write) begin
                tx_buf   <= tx_data;
                tx_ready <= 1'b0;
            end else if (do_load) begin
                tx_ready <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (cs_n_ne) begin
                        state     <= ST_XFER;
                        bit_cnt   <= '0;
                        miso_oe   <= 1'b1;
                        load_pend <= P_CPHA;
                    end
                end
                ST_XFER: begin
                    if (sample_edge) begin
                        rx_shift <= rx_next[P_DATA_W-2:0];
                        bit_cnt  <= word_done ? '0 : bit_cnt + 1'b1;
                    end
                    if (word_done) begin
                        rx_data   <= rx_next;
                        rx_valid  <= 1'b1;
                        load_pend <= 1'b1;
                    end else if (do_load) begin
                        load_pend <= 1'b0;
                    end
                    // A sample in the closing cycle counts before the bit count is judged.
                    if (frame_end) begin
                        state     <= ST_IDLE;
                        miso_oe   <= 1'b0;
                        bit_cnt   <= '0;
                        load_pend <= 1'b0;
                        frame_err <= sample_edge ? !word_done : (bit_cnt != '0);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_slave_ctrl.sv
// Scoreboard bench: one DUT per SPI mode, a bit-level master model, and a monitor
// that pops expected rx words / underrun / frame-error events as the DUTs pulse.
module tb_spi_slave_ctrl;
    localparam int W       = 8;
    localparam int N_MODES = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic               sclk_pe  = 1'b0;
    logic               sclk_ne  = 1'b0;
    logic               mosi     = 1'b0;
    logic [W-1:0]       tx_data  = '0;
    logic [N_MODES-1:0] cs_n     = '1;
    logic [N_MODES-1:0] cs_n_ne  = '0;
    logic [N_MODES-1:0] cs_n_pe  = '0;
    logic [N_MODES-1:0] tx_valid = '0;

    logic         miso        [N_MODES];
    logic         miso_oe     [N_MODES];
    logic         tx_ready    [N_MODES];
    logic [W-1:0] rx_data     [N_MODES];
    logic         rx_valid    [N_MODES];
    logic         tx_underrun [N_MODES];
    logic         frame_err   [N_MODES];

    for (genvar g = 0; g < N_MODES; g++) begin : g_dut
        spi_slave_ctrl #(
            .P_DATA_W(W),
            .P_CPOL  (g >= 2),
            .P_CPHA  ((g % 2) == 1)
        ) u_dut (
            .clk        (clk),
            .rst        (rst),
            .sclk_pe    (sclk_pe),
            .sclk_ne    (sclk_ne),
            .cs_n       (cs_n[g]),
            .cs_n_ne    (cs_n_ne[g]),
            .cs_n_pe    (cs_n_pe[g]),
            .mosi       (mosi),
            .miso       (miso[g]),
            .miso_oe    (miso_oe[g]),
            .tx_data    (tx_data),
            .tx_valid   (tx_valid[g]),
            .tx_ready   (tx_ready[g]),
            .rx_data    (rx_data[g]),
            .rx_valid   (rx_valid[g]),
            .tx_underrun(tx_underrun[g]),
            .frame_err  (frame_err[g])
        );
    end

    typedef struct {
        int           mode;
        logic [W-1:0] data;
    } rx_exp_t;

    rx_exp_t exp_rx[$];
    int      exp_under[$];
    int      exp_ferr[$];

    // Reference model: holding buffer contents and last received word per mode.
    bit           buf_full_m [N_MODES];
    logic [W-1:0] buf_val_m  [N_MODES];
    logic [W-1:0] rx_hold_m  [N_MODES];
    logic [W-1:0] frame_mosi [4];

    int n_vec  = 0;
    int n_miss = 0;

    task automatic check_bit(input string name, input int m, input logic got, input logic exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s mode%0d: got %b expected %b", name, m, got, exp);
        end
    endtask

    task automatic check_word(input string name, input int m, input logic [W-1:0] got,
                              input logic [W-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s mode%0d: got 0x%0h expected 0x%0h", name, m, got, exp);
        end
    endtask

    task automatic check_int(input string name, input int m, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_miss++;
            $display("FAIL %s mode%0d: got %0d expected %0d", name, m, got, exp);
        end
    endtask

    task automatic unexpected(input string name, input int m);
        n_vec++;
        n_miss++;
        $display("FAIL unexpected %s pulse mode%0d: got 1 expected 0", name, m);
    endtask

    // Monitor: every DUT pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        for (int g = 0; g < N_MODES; g++) begin
            if (rx_valid[g] === 1'b1) begin
                if (exp_rx.size() == 0) unexpected("rx_valid", g);
                else begin
                    rx_exp_t e;
                    e = exp_rx.pop_front();
                    check_int("rx_source", g, g, e.mode);
                    check_word("rx_data", g, rx_data[g], e.data);
                end
            end
            if (tx_underrun[g] === 1'b1) begin
                if (exp_under.size() == 0) unexpected("tx_underrun", g);
                else check_int("underrun_source", g, g, exp_under.pop_front());
            end
            if (frame_err[g] === 1'b1) begin
                if (exp_ferr.size() == 0) unexpected("frame_err", g);
                else check_int("frame_err_source", g, g, exp_ferr.pop_front());
            end
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic sclk_edge(input bit rising);
        if (rising) sclk_pe = 1'b1;
        else        sclk_ne = 1'b1;
        tick();
        sclk_pe = 1'b0;
        sclk_ne = 1'b0;
        tick(3);
    endtask

    // A word start takes the buffered word if one is waiting, otherwise zeros plus an underrun.
    task automatic model_load(input int m, output logic [W-1:0] word);
        if (buf_full_m[m]) begin
            word          = buf_val_m[m];
            buf_full_m[m] = 1'b0;
        end else begin
            word = '0;
            exp_under.push_back(m);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N_MODES; i++) begin
            buf_full_m[i] = 1'b0;
            buf_val_m[i]  = '0;
            rx_hold_m[i]  = '0;
        end
    endtask

    task automatic push_rx(input int m, input logic [W-1:0] d);
        rx_exp_t e;
        e.mode = m;
        e.data = d;
        exp_rx.push_back(e);
        rx_hold_m[m] = d;
    endtask

    task automatic write_tx(input int m, input logic [W-1:0] d);
        check_bit("tx_ready_before_write", m, tx_ready[m], !buf_full_m[m]);
        tx_data     = d;
        tx_valid[m] = 1'b1;
        tick();
        tx_valid[m] = 1'b0;
        tick();
        buf_full_m[m] = 1'b1;
        buf_val_m[m]  = d;
        check_bit("tx_ready_after_write", m, tx_ready[m], !buf_full_m[m]);
    endtask

    task automatic check_reset(input int m);
        check_bit("rst_miso", m, miso[m], 1'b0);
        check_bit("rst_miso_oe", m, miso_oe[m], 1'b0);
        check_bit("rst_tx_ready", m, tx_ready[m], 1'b1);
        check_word("rst_rx_data", m, rx_data[m], '0);
        check_bit("rst_pulses", m, rx_valid[m] | tx_underrun[m] | frame_err[m], 1'b0);
    endtask

    // Master: nbits clocked MSB-first from frame_mosi; optional tx write after bit wr_bit;
    // abort=1 ends the frame with a reset instead of a cs_n rise.
    task automatic run_frame(input int m, input int nbits, input int wr_bit,
                             input logic [W-1:0] wr_val, input bit abort);
        bit           cpha;
        bit           lead_rise;
        logic [W-1:0] cur;
        logic [W-1:0] mw;
        int           bi;
        cpha      = (m % 2) == 1;
        lead_rise = (m < 2);
        cur       = '0;
        if (!cpha) model_load(m, cur);
        cs_n[m]    = 1'b0;
        cs_n_ne[m] = 1'b1;
        tick();
        cs_n_ne[m] = 1'b0;
        tick(2);
        check_bit("miso_oe_in_frame", m, miso_oe[m], 1'b1);
        for (int b = 0; b < nbits; b++) begin
            bi = W - 1 - (b % W);
            mw = frame_mosi[b / W];
            if (!cpha) begin
                mosi = mw[bi];
                check_bit("miso_bit", m, miso[m], cur[bi]);
                if (bi == 0) push_rx(m, mw);
                sclk_edge(lead_rise);
                if (bi == 0) model_load(m, cur);
                sclk_edge(!lead_rise);
            end else begin
                if (bi == W - 1) model_load(m, cur);
                sclk_edge(lead_rise);
                mosi = mw[bi];
                check_bit("miso_bit", m, miso[m], cur[bi]);
                if (bi == 0) push_rx(m, mw);
                sclk_edge(!lead_rise);
            end
            if (b == wr_bit) write_tx(m, wr_val);
        end
        if (abort) begin
            rst = 1'b1;
            tick(2);
            model_reset();
            for (int i = 0; i < N_MODES; i++) check_reset(i);
            cs_n[m] = 1'b1;
            rst     = 1'b0;
            tick(2);
        end else begin
            if (nbits % W != 0) exp_ferr.push_back(m);
            cs_n[m]    = 1'b1;
            cs_n_pe[m] = 1'b1;
            tick();
            cs_n_pe[m] = 1'b0;
            tick(2);
            check_bit("miso_oe_after_frame", m, miso_oe[m], 1'b0);
            check_word("rx_data_held", m, rx_data[m], rx_hold_m[m]);
            check_bit("tx_ready_after_frame", m, tx_ready[m], !buf_full_m[m]);
        end
        check_int("pending_rx", m, exp_rx.size(), 0);
        check_int("pending_underrun", m, exp_under.size(), 0);
        check_int("pending_frame_err", m, exp_ferr.size(), 0);
        exp_rx.delete();
        exp_under.delete();
        exp_ferr.delete();
    endtask

    initial begin
        int m;
        int nw;
        int nbits;
        int wr_bit;
        model_reset();
        tick(3);
        for (int i = 0; i < N_MODES; i++) check_reset(i);
        rst = 1'b0;
        tick(2);

        // Mode 0 single word.
        write_tx(0, 8'hA5);
        frame_mosi[0] = 8'h3C;
        run_frame(0, W, -1, '0, 1'b0);

        // Two back-to-back words, second tx word written during the first.
        write_tx(0, 8'h12);
        frame_mosi[0] = 8'hF0;
        frame_mosi[1] = 8'h0F;
        run_frame(0, 2 * W, 3, 8'h34, 1'b0);

        // No tx data at all.
        frame_mosi[0] = 8'h96;
        run_frame(0, W, -1, '0, 1'b0);

        // Frame cut short after five samples.
        frame_mosi[0] = 8'hFF;
        run_frame(0, 5, -1, '0, 1'b0);

        // Remaining modes.
        for (int k = 1; k < N_MODES; k++) begin
            write_tx(k, 8'h81);
            frame_mosi[0] = 8'h81;
            run_frame(k, W, -1, '0, 1'b0);
        end

        // Reset mid-frame, then a clean frame.
        write_tx(0, 8'hC3);
        frame_mosi[0] = 8'hAA;
        run_frame(0, 3, -1, '0, 1'b1);
        write_tx(0, 8'h55);
        frame_mosi[0] = 8'h55;
        run_frame(0, W, -1, '0, 1'b0);

        // Randomized frames across all modes.
        repeat (24) begin
            m  = $urandom_range(0, N_MODES - 1);
            nw = $urandom_range(1, 3);
            for (int w = 0; w < 4; w++) frame_mosi[w] = W'($urandom);
            nbits = nw * W;
            if ($urandom_range(0, 3) == 0) nbits += $urandom_range(1, W - 1);
            if (!buf_full_m[m] && $urandom_range(0, 1) == 1) write_tx(m, W'($urandom));
            wr_bit = -1;
            if ($urandom_range(0, 1) == 1)
                wr_bit = W * $urandom_range(0, nw - 1) + $urandom_range(1, W - 2);
            run_frame(m, nbits, wr_bit, W'($urandom), 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
